// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel push-button conditioner.
// Each key is synchronised, debounced by a stable-time counter and converted
// into a clean pressed level plus one-cycle press, release, long-press and
// optional auto-repeat pulses. Channels share only the clock and reset.

module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int CNT_MAX    = 5_000_000,
  parameter int LONG_MAX   = 100_000_000,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_MAX = 10_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] rep_pulse,
  output logic              any_pressed
);

  // Debounce counter only needs to reach CNT_MAX-1 before it is cleared.
  localparam int CW = $clog2(CNT_MAX);
  // One hold counter serves both the long-press and the repeat interval.
  localparam int HOLD_MAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
  localparam int HW = $clog2(HOLD_MAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MAX - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_MAX - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  // Raw level of a released key; the synchroniser idles at this value.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  // Next debounced level of every channel, used to register any_pressed
  // so that it lines up with key_pressed.
  logic [N_KEYS-1:0] pressed_next;

  genvar i;
  generate
    for (i = 0; i < N_KEYS; i++) begin : g_key
      logic          s1;
      logic          s2;
      logic [CW-1:0] db_cnt;
      logic          pressed;
      logic          press_q;
      logic          release_q;
      logic          long_q;
      logic          rep_q;
      logic [HW-1:0] hold_cnt;
      hold_state_e   state;

      logic s2_pressed;
      logic accept;

      // Synchronised level translated to "1 = pressed" regardless of polarity.
      assign s2_pressed = s2 ^ IDLE_LVL;

      // A new level is accepted once the synchroniser has been stable and
      // different from the debounced level for CNT_MAX consecutive cycles.
      assign accept = (s1 == s2) && (s2_pressed != pressed) && (db_cnt == CNT_LAST);

      assign pressed_next[i] = pressed ^ accept;

      // Synchroniser, stable-time counter, debounced level and edge pulses.
      // Any disagreement between the two sync stages, or a return to the
      // already accepted level, restarts the stable-time measurement.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1        <= IDLE_LVL;
          s2        <= IDLE_LVL;
          db_cnt    <= '0;
          pressed   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          s1        <= key_in[i];
          s2        <= s1;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          if (s1 != s2) begin
            db_cnt <= '0;
          end else if (s2_pressed != pressed) begin
            if (db_cnt == CNT_LAST) begin
              db_cnt    <= '0;
              pressed   <= s2_pressed;
              press_q   <= s2_pressed;
              release_q <= ~s2_pressed;
            end else begin
              db_cnt <= db_cnt + CNT_ONE;
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end

      // Hold FSM: times the continuous press for the long pulse and then the
      // repeat period. An accepted release always takes priority, so a release
      // landing on a threshold cycle suppresses the long/repeat pulse.
      always_ff @(posedge clk) begin
        if (rst) begin
          state    <= IDLE;
          hold_cnt <= '0;
          long_q   <= 1'b0;
          rep_q    <= 1'b0;
        end else begin
          long_q <= 1'b0;
          rep_q  <= 1'b0;
          if (accept && !s2_pressed) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            case (state)
              IDLE: begin
                hold_cnt <= '0;
                if (accept && s2_pressed) begin
                  state <= HOLD;
                end
              end
              HOLD: begin
                if (hold_cnt == LONG_LAST) begin
                  long_q   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= LONG;
                end else begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
                end
              end
              LONG: begin
                if (REPEAT_EN != 0) begin
                  if (hold_cnt == REP_LAST) begin
                    rep_q    <= 1'b1;
                    hold_cnt <= '0;
                  end else begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                  end
                end else begin
                  hold_cnt <= '0;
                end
              end
              default: begin
                state    <= IDLE;
                hold_cnt <= '0;
              end
            endcase
          end
        end
      end

      assign key_pressed[i]   = pressed;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign long_pulse[i]    = long_q;
      assign rep_pulse[i]     = rep_q;
    end
  endgenerate

  // Registered OR of all debounced levels, aligned with key_pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_pressed <= 1'b0;
    end else begin
      any_pressed <= |pressed_next;
    end
  end

endmodule
